pll_supervisor: RTL
===================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL provide parameter P_NUM_OUT, default 4: number of sequenced domain resets, legal range 1..8.
REQ-002 SHALL provide parameter P_PLL_RST_CYCLES, default 8: PLL reset pulse length in cycles, minimum 1.
REQ-003 SHALL provide parameter P_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a PLL reset is retried.
REQ-004 SHALL provide parameter P_LOCK_CYCLES, default 1024: consecutive locked cycles required to accept lock.
REQ-005 SHALL provide parameter P_STAGGER, default 16: cycles between successive domain reset releases, minimum 1.
REQ-006 SHALL provide parameter P_CNT_W, default 8: width of the lock-loss counter.
REQ-007 SHALL provide port piul1RefClock, input, 1 bit: sole clock, free-running reference clock.
REQ-008 SHALL provide port piul1Reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-009 SHALL provide port piul1Locked, input, 1 bit: PLL lock indication, asynchronous to piul1RefClock.
REQ-010 SHALL provide port piul1ClearStats, input, 1 bit: synchronous clear of the loss counter.
REQ-011 SHALL provide port poul1PllReset, output, 1 bit: active-high reset request to the PLL.
REQ-012 SHALL provide port poulResets_n, output, P_NUM_OUT bits: active-low domain resets.
REQ-013 SHALL provide port poul1Ready, output, 1 bit: high when all domain resets are released and lock is held.
REQ-014 SHALL provide port poul3State, output, 3 bits: state code (0 PLL_RST, 1 WAIT_LOCK, 2 FILTER, 3 RELEASE, 4 RUN).
REQ-015 SHALL provide port poulLossCount, output, P_CNT_W bits: saturating count of lock losses.

Function
REQ-016 SHALL synchronise piul1Locked through two flops; "lock" in this document means the synchronised value (2-cycle latency).
REQ-017 PLL_RST: poul1PllReset=1 for exactly P_PLL_RST_CYCLES cycles, then WAIT_LOCK; lock is ignored in this state.
REQ-018 WAIT_LOCK: poul1PllReset=0; lock=1 -> FILTER next cycle; P_TIMEOUT cycles without lock -> PLL_RST.
REQ-019 FILTER: counts consecutive lock=1 cycles; lock=0 -> WAIT_LOCK, with the timeout counter restarted; count reaching P_LOCK_CYCLES -> RELEASE.
REQ-020 RELEASE: poulResets_n[0] goes high on the first RELEASE cycle; bit i goes high i*P_STAGGER cycles later; bits stay high once released.
REQ-021 RELEASE -> RUN on the cycle after bit P_NUM_OUT-1 is released; poul1Ready=1 exactly in RUN.
REQ-022 Lock=0 in RELEASE or RUN: on the next edge, all poulResets_n=0, poul1Ready=0, state=PLL_RST, and the loss counter increments.
REQ-023 Loss counter SHALL saturate at 2^P_CNT_W-1 and never wrap.
REQ-024 piul1ClearStats SHALL zero the counter on the next edge; if a clear and a loss occur together, clear wins (result 0).
REQ-025 All outputs SHALL be registered; poulResets_n SHALL be glitch-free and never released out of index order.
REQ-026 With P_NUM_OUT=1, RUN SHALL be entered on the cycle after the first RELEASE cycle.

Reset
REQ-027 While piul1Reset_n=0: state PLL_RST, poul1PllReset=1, poulResets_n all 0, poul1Ready=0, poulLossCount=0, synchroniser and counters cleared.
REQ-028 Assertion SHALL take effect asynchronously; release is sampled on piul1RefClock; the PLL_RST count starts at the first edge after release.
REQ-029 Reset mid-RELEASE or mid-RUN SHALL immediately re-assert every domain reset.

Verification (P_NUM_OUT=4, P_PLL_RST_CYCLES=8, P_TIMEOUT=100, P_LOCK_CYCLES=32, P_STAGGER=4, P_CNT_W=2)
REQ-030 Clean bring-up: release reset at edge 0, piul1Locked=1 from edge 20 -> poul1PllReset high on edges 0-7, FILTER at edge 23, bits 0/1/2/3 released at edges 56/60/64/68, Ready at edge 69.
REQ-031 Timeout: piul1Locked held 0 -> PLL_RST re-entered at edge 108, poul1PllReset high for 8 cycles, repeating every 108 cycles.
REQ-032 Glitchy lock: piul1Locked drops for 3 cycles at FILTER count 20 -> return to WAIT_LOCK, no reset released, full 32-cycle count required after lock returns.
REQ-033 Loss in RUN: piul1Locked drops -> within 3 edges all resets 0, Ready 0, LossCount 1, poul1PllReset high 8 cycles, then a full re-sequence.
REQ-034 Saturation and clear: 5 losses -> LossCount=3; clear pulsed on the same edge as a 6th loss -> LossCount=0.
REQ-035 Async reset at the second RELEASE stagger -> poulResets_n=0000 without waiting for a clock edge, state 0, LossCount 0.

Source files
------------

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, then releases domain
// resets one by one; any loss of lock after qualification restarts the sequence.
module pll_supervisor #(
    parameter int P_NUM_OUT        = 4,
    parameter int P_PLL_RST_CYCLES = 8,
    parameter int P_TIMEOUT        = 65536,
    parameter int P_LOCK_CYCLES    = 1024,
    parameter int P_STAGGER        = 16,
    parameter int P_CNT_W          = 8
) (
    input  logic                 piul1RefClock,
    input  logic                 piul1Reset_n,
    input  logic                 piul1Locked,
    input  logic                 piul1ClearStats,
    output logic                 poul1PllReset,
    output logic [P_NUM_OUT-1:0] poulResets_n,
    output logic                 poul1Ready,
    output logic [2:0]           poul3State,
    output logic [P_CNT_W-1:0]   poulLossCount
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMR_MAX = max2(max2(P_TIMEOUT, P_LOCK_CYCLES), max2(P_PLL_RST_CYCLES, P_STAGGER));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [P_CNT_W-1:0] LOSS_MAX = '1;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [P_NUM_OUT-1:0] rst_n_d;
    logic                 lock_meta, lock_s;
    logic                 loss;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of the others, whatever order the blocks run in.
    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= piul1Locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) state_q <= PLL_RST;
        else               state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        rst_n_d = poulResets_n;
        loss    = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (tmr_q == TMR_W'(P_PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = FILTER;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(P_TIMEOUT - 1)) begin
                    state_d = PLL_RST;
                    tmr_d   = '0;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(P_LOCK_CYCLES)) begin
                    state_d = RELEASE;
                    tmr_d   = '0;
                    rst_n_d = P_NUM_OUT'(1);
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    tmr_d   = '0;
                    rst_n_d = '0;
                    loss    = 1'b1;
                end else if (state_q == RUN) begin
                    tmr_d = tmr_q;
                end else if (poulResets_n[P_NUM_OUT-1]) begin
                    state_d = RUN;
                end else if (tmr_q == TMR_W'(P_STAGGER - 1)) begin
                    // Shifting a one in from bit 0 makes out-of-order release impossible.
                    rst_n_d = (poulResets_n << 1) | P_NUM_OUT'(1);
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                tmr_d   = '0;
                rst_n_d = '0;
            end
        endcase
    end

    always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            tmr_q         <= '0;
            poulResets_n  <= '0;
            poul1PllReset <= 1'b1;
            poul1Ready    <= 1'b0;
            poulLossCount <= '0;
        end else begin
            tmr_q         <= tmr_d;
            poulResets_n  <= rst_n_d;
            poul1PllReset <= (state_d == PLL_RST);
            poul1Ready    <= (state_d == RUN);
            if (piul1ClearStats)
                poulLossCount <= '0;
            else if (loss && poulLossCount != LOSS_MAX)
                poulLossCount <= poulLossCount + 1'b1;
        end
    end

    assign poul3State = state_q;

endmodule
